// File: rtl/frame_buffer_multi.sv
// Double/triple frame buffer between the raycaster pixel stream and the video timing generator.
// Buffer roles rotate only at video frame end; the read side upscales, looks up the palette and applies shading.
module frame_buffer_multi #(
  parameter int PIXEL_WIDTH        = 9,
  parameter int FULL_SCREEN_WIDTH  = 1280,
  parameter int FULL_SCREEN_HEIGHT = 720,
  parameter int SCALE_SHIFT        = 2,
  parameter int NUM_BUFS           = 2,
  parameter int ADDR_W             = 16,
  parameter logic [(2**(PIXEL_WIDTH-1))-1:0][23:0] PALETTE = '0
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_n_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   video_last_pixel_in,
  input  logic                   wr_valid_in,
  output logic                   wr_ready_out,
  input  logic [ADDR_W-1:0]      wr_addr_in,
  input  logic [PIXEL_WIDTH-1:0] wr_pixel_in,
  input  logic                   wr_frame_done_in,
  output logic [23:0]            rgb_out,
  output logic                   rgb_valid_out,
  output logic                   swap_out,
  output logic [1:0]             disp_buf_out,
  output logic [7:0]             drop_count_out,
  output logic                   wr_oob_out
);

  localparam int SCREEN_W = FULL_SCREEN_WIDTH >> SCALE_SHIFT;
  localparam int SCREEN_H = FULL_SCREEN_HEIGHT >> SCALE_SHIFT;
  localparam int DEPTH    = SCREEN_W * SCREEN_H;
  localparam int MEM_N    = NUM_BUFS * DEPTH;
  localparam int MEM_AW   = $clog2(MEM_N);
  localparam logic [10:0] FULL_W = 11'(FULL_SCREEN_WIDTH);
  localparam logic [9:0]  FULL_H = 10'(FULL_SCREEN_HEIGHT);

  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
    $error("frame_buffer_multi: NUM_BUFS must be 2 or 3");
  end

  logic [1:0] disp_q, disp_d;
  logic [1:0] wr_q, wr_d;
  logic       pend_v_q, pend_v_d;
  logic [7:0] drop_q, drop_d;
  logic       swap_d;
  logic [1:0] third;

  // With three buffers the indices sum to 3, so the non-display, non-write
  // buffer is either the pending frame or the free one.
  assign third = 2'(2'd3 - disp_q - wr_q);

  always_comb begin
    disp_d   = disp_q;
    wr_d     = wr_q;
    pend_v_d = pend_v_q;
    drop_d   = drop_q;
    swap_d   = 1'b0;
    if (wr_frame_done_in) begin
      if (NUM_BUFS == 3) begin
        if (pend_v_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        wr_d     = third;
        pend_v_d = 1'b1;
      end else begin
        pend_v_d = 1'b1;
      end
    end
    if (video_last_pixel_in && pend_v_d) begin
      if (NUM_BUFS == 3) begin
        disp_d = wr_frame_done_in ? wr_q : third;
      end else begin
        disp_d = wr_q;
        wr_d   = disp_q;
      end
      pend_v_d = 1'b0;
      swap_d   = 1'b1;
    end
  end

  assign wr_ready_out   = (NUM_BUFS == 3) ? 1'b1 : !pend_v_q;
  assign disp_buf_out   = disp_q;
  assign drop_count_out = drop_q;

  // Write side
  logic [PIXEL_WIDTH-1:0] mem [MEM_N];
  logic              wr_fire;
  logic              wr_in_range;
  logic [MEM_AW-1:0] wr_idx;

  assign wr_fire     = wr_valid_in && wr_ready_out;
  assign wr_in_range = 32'(wr_addr_in) < 32'(DEPTH);
  assign wr_idx      = MEM_AW'(32'(wr_q) * 32'(DEPTH) + 32'(wr_addr_in));

  always_ff @(posedge pixel_clk_in) begin
    if (rst_n_in && wr_fire && wr_in_range) mem[wr_idx] <= wr_pixel_in;
  end

  // Read side: the display buffer is folded into the address at the first
  // stage, so a swap can never split one pixel across buffers.
  logic              active_d;
  logic [31:0]       rd_lin;
  logic [MEM_AW-1:0] rd_idx_d, rd_idx_q;
  logic [PIXEL_WIDTH-1:0] pix_q;
  logic [23:0]       pal_q;
  logic              shade_q;
  logic [2:0]        act_q;

  assign active_d = (hcount_in < FULL_W) && (vcount_in < FULL_H);
  assign rd_lin   = 32'(hcount_in >> SCALE_SHIFT) + 32'(SCREEN_W) * 32'(vcount_in >> SCALE_SHIFT);
  assign rd_idx_d = active_d ? MEM_AW'(32'(disp_q) * 32'(DEPTH) + rd_lin) : '0;

  always_ff @(posedge pixel_clk_in) begin
    rd_idx_q <= rd_idx_d;
    pix_q    <= mem[rd_idx_q];
    pal_q    <= PALETTE[pix_q[PIXEL_WIDTH-2:0]];
    shade_q  <= pix_q[PIXEL_WIDTH-1];
  end

  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      disp_q        <= 2'd0;
      wr_q          <= 2'd1;
      pend_v_q      <= 1'b0;
      drop_q        <= 8'd0;
      swap_out      <= 1'b0;
      wr_oob_out    <= 1'b0;
      act_q         <= '0;
      rgb_valid_out <= 1'b0;
      rgb_out       <= 24'd0;
    end else begin
      disp_q        <= disp_d;
      wr_q          <= wr_d;
      pend_v_q      <= pend_v_d;
      drop_q        <= drop_d;
      swap_out      <= swap_d;
      wr_oob_out    <= wr_fire && !wr_in_range;
      act_q         <= {act_q[1:0], active_d};
      rgb_valid_out <= act_q[2];
      if (!act_q[2])    rgb_out <= 24'd0;
      else if (shade_q) rgb_out <= (pal_q >> 1) & 24'h7F7F7F;
      else              rgb_out <= pal_q;
    end
  end

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Bench for frame_buffer_multi: double and triple instances share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_frame_buffer_multi;

  localparam int DEPTH = 57600;

  function automatic logic [255:0][23:0] make_pal();
    logic [255:0][23:0] p;
    for (int i = 0; i < 256; i++) p[i] = {8'(i * 37 + 11), 8'(i * 101), 8'(255 - i)};
    p[3] = 24'h204080;
    return p;
  endfunction
  localparam logic [255:0][23:0] PAL = make_pal();

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [10:0] hcount = 11'd1300;
  logic [9:0]  vcount = 10'd0;
  logic        vlp = 1'b0, wr_valid = 1'b0, fd = 1'b0;
  logic [15:0] wr_addr = 16'd0;
  logic [8:0]  wr_pixel = 9'd0;

  logic [23:0] rgb2, rgb3;
  logic        valid2, valid3, swap2, swap3, ready2, ready3, oob2, oob3;
  logic [1:0]  disp2, disp3;
  logic [7:0]  drop2, drop3;

  frame_buffer_multi #(.NUM_BUFS(2), .PALETTE(PAL)) dut2 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .video_last_pixel_in(vlp), .wr_valid_in(wr_valid), .wr_ready_out(ready2),
    .wr_addr_in(wr_addr), .wr_pixel_in(wr_pixel), .wr_frame_done_in(fd),
    .rgb_out(rgb2), .rgb_valid_out(valid2), .swap_out(swap2), .disp_buf_out(disp2),
    .drop_count_out(drop2), .wr_oob_out(oob2));

  frame_buffer_multi #(.NUM_BUFS(3), .PALETTE(PAL)) dut3 (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .video_last_pixel_in(vlp), .wr_valid_in(wr_valid), .wr_ready_out(ready3),
    .wr_addr_in(wr_addr), .wr_pixel_in(wr_pixel), .wr_frame_done_in(fd),
    .rgb_out(rgb3), .rgb_valid_out(valid3), .swap_out(swap3), .disp_buf_out(disp3),
    .drop_count_out(drop3), .wr_oob_out(oob3));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: index 0 = double buffer, 1 = triple buffer
  logic [8:0]  mem_m [int];
  int          m_disp[2], m_wr[2], m_pend[2], m_drop[2];
  bit          m_pv[2], m_ready[2], e_swap[2], e_oob[2];
  int          free_q[$];
  logic [23:0] p_rgb[2][4];
  bit          p_v[2][4], p_known[2][4];

  function automatic int key(int k, int b, int a);
    return k * 4000000 + b * 1000000 + a;
  endfunction

  function automatic logic [23:0] expect_rgb(logic [8:0] pix);
    logic [23:0] p;
    p = PAL[pix[7:0]];
    return pix[8] ? ((p >> 1) & 24'h7F7F7F) : p;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_disp[k] = 0; m_wr[k] = 1; m_pv[k] = 0; m_pend[k] = 0; m_drop[k] = 0;
        m_ready[k] = 1; e_swap[k] = 0; e_oob[k] = 0;
        for (int s = 0; s < 4; s++) begin p_v[k][s] = 0; p_rgb[k][s] = 0; p_known[k][s] = 1; end
        if (k == 1) begin free_q.delete(); free_q.push_back(2); end
      end else begin
        int a, nw, old_disp;
        bit acc, act, known;
        logic [23:0] e;
        old_disp = m_disp[k];
        acc = wr_valid && m_ready[k];
        e_oob[k] = acc && (int'(wr_addr) >= DEPTH);
        if (acc && int'(wr_addr) < DEPTH) mem_m[key(k, m_wr[k], int'(wr_addr))] = wr_pixel;
        act = (hcount < 11'd1280) && (vcount < 10'd720);
        e = 24'd0; known = 1;
        if (act) begin
          a = int'(hcount) / 4 + 320 * (int'(vcount) / 4);
          if (mem_m.exists(key(k, old_disp, a))) e = expect_rgb(mem_m[key(k, old_disp, a)]);
          else known = 0;
        end
        for (int s = 3; s > 0; s--) begin
          p_v[k][s] = p_v[k][s-1]; p_rgb[k][s] = p_rgb[k][s-1]; p_known[k][s] = p_known[k][s-1];
        end
        p_v[k][0] = act; p_rgb[k][0] = e; p_known[k][0] = known;
        if (fd) begin
          if (k == 0) begin
            if (!m_pv[0]) begin m_pv[0] = 1; m_pend[0] = m_wr[0]; m_wr[0] = -1; end
          end else begin
            if (m_pv[1]) begin
              if (m_drop[1] < 255) m_drop[1]++;
              nw = m_pend[1];
            end else nw = free_q.pop_front();
            m_pend[1] = m_wr[1]; m_pv[1] = 1; m_wr[1] = nw;
          end
        end
        e_swap[k] = 0;
        if (vlp && m_pv[k]) begin
          if (k == 0) m_wr[0] = m_disp[0];
          else free_q.push_back(m_disp[1]);
          m_disp[k] = m_pend[k]; m_pv[k] = 0; e_swap[k] = 1;
        end
        m_ready[k] = (k == 1) || !m_pv[k];
      end
    end
  endtask

  task automatic check_all();
    check_eq("d2_ready", 32'(ready2), 32'(m_ready[0]));
    check_eq("d3_ready", 32'(ready3), 32'(m_ready[1]));
    check_eq("d2_disp",  32'(disp2),  32'(m_disp[0]));
    check_eq("d3_disp",  32'(disp3),  32'(m_disp[1]));
    check_eq("d2_swap",  32'(swap2),  32'(e_swap[0]));
    check_eq("d3_swap",  32'(swap3),  32'(e_swap[1]));
    check_eq("d2_drop",  32'(drop2),  32'(m_drop[0]));
    check_eq("d3_drop",  32'(drop3),  32'(m_drop[1]));
    check_eq("d2_oob",   32'(oob2),   32'(e_oob[0]));
    check_eq("d3_oob",   32'(oob3),   32'(e_oob[1]));
    check_eq("d2_valid", 32'(valid2), 32'(p_v[0][3]));
    check_eq("d3_valid", 32'(valid3), 32'(p_v[1][3]));
    if (p_known[0][3]) check_eq("d2_rgb", 32'(rgb2), 32'(p_rgb[0][3]));
    if (p_known[1][3]) check_eq("d3_rgb", 32'(rgb3), 32'(p_rgb[1][3]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    wr_valid = 0; fd = 0; vlp = 0;
    hcount = 11'd1300; vcount = 10'd0;
  endtask

  task automatic read_px(input logic [10:0] h, input logic [9:0] v);
    hcount = h; vcount = v;
    repeat (4) cyc();
  endtask

  task automatic fill_region();
    for (int i = 0; i < 32; i++) begin
      wr_valid = 1;
      wr_addr  = 16'((i / 8) * 320 + i % 8);
      wr_pixel = (i == 0) ? 9'h103 : (i == 5) ? 9'h003 : 9'($urandom_range(0, 511));
      cyc();
    end
  endtask

  initial begin
    int zero_cnt, one_cnt, drop_before, disp_before;
    logic [8:0] pk [3];
    pk[0] = 9'h0A7; pk[1] = 9'h1C2; pk[2] = 9'h055;

    // reset held 3 cycles
    rst_n = 0;
    repeat (3) cyc();
    check_eq("rst_rgb", 32'(rgb2 | rgb3), 32'd0);
    check_eq("rst_ready", 32'({ready2, ready3}), 32'd3);
    check_eq("rst_disp", 32'({disp2, disp3}), 32'd0);
    rst_n = 1;

    // put known content in every buffer of both instances
    fill_region(); fd = 1; cyc(); vlp = 1; cyc();
    fill_region(); fd = 1; vlp = 1; cyc();
    fill_region(); fd = 1; cyc(); vlp = 1; cyc();

    // latency and palette, shade, inactive region
    read_px(11'd20, 10'd0);
    check_eq("lat_rgb2", 32'(rgb2), 32'h204080);
    check_eq("lat_rgb3", 32'(rgb3), 32'h204080);
    check_eq("lat_valid", 32'({valid2, valid3}), 32'd3);
    read_px(11'd0, 10'd0);
    check_eq("shade_rgb2", 32'(rgb2), 32'h102040);
    check_eq("shade_rgb3", 32'(rgb3), 32'h102040);
    read_px(11'd1280, 10'd0);
    check_eq("h1280_valid", 32'({valid2, valid3}), 32'd0);
    check_eq("h1280_rgb", 32'(rgb2 | rgb3), 32'd0);

    // double buffer stalls until the swap 100 cycles later
    disp_before = m_disp[0];
    fd = 1; cyc();
    zero_cnt = (ready2 == 1'b0) ? 1 : 0;
    for (int i = 0; i < 99; i++) begin cyc(); if (!ready2) zero_cnt++; end
    vlp = 1; cyc();
    check_eq("dbl_stall_cycles", 32'(zero_cnt), 32'd100);
    check_eq("dbl_swap", 32'(swap2), 32'd1);
    check_eq("dbl_disp", 32'(disp2), 32'(1 - disp_before));
    check_eq("dbl_ready", 32'(ready2), 32'd1);

    // triple buffer: three completed frames before one frame end
    drop_before = m_drop[1];
    one_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      wr_valid = 1; wr_addr = 16'd5; wr_pixel = pk[f]; fd = 1; cyc();
      if (ready3) one_cnt++;
      cyc();
      if (ready3) one_cnt++;
    end
    vlp = 1; cyc();
    check_eq("tri_drop", 32'(drop3), 32'(drop_before + 2));
    check_eq("tri_ready", 32'(one_cnt), 32'd6);
    read_px(11'd20, 10'd0);
    check_eq("tri_third_frame", 32'(rgb3), 32'(expect_rgb(pk[2])));

    // out-of-range write and simultaneous frame done / frame end
    wr_valid = 1; wr_addr = 16'd57600; wr_pixel = 9'h1FF; cyc();
    check_eq("oob_pulse", 32'({oob2, oob3}), 32'd3);
    cyc();
    check_eq("oob_clear", 32'({oob2, oob3}), 32'd0);
    wr_valid = 1; wr_addr = 16'd57599; wr_pixel = 9'h012; cyc();
    check_eq("oob_edge_inrange", 32'({oob2, oob3}), 32'd0);
    wr_valid = 1; wr_addr = 16'd5; wr_pixel = 9'h0B1; fd = 1; vlp = 1; cyc();
    check_eq("sim_swap", 32'({swap2, swap3}), 32'd3);
    read_px(11'd23, 10'd3);
    check_eq("sim_rgb2", 32'(rgb2), 32'(expect_rgb(9'h0B1)));
    check_eq("sim_rgb3", 32'(rgb3), 32'(expect_rgb(9'h0B1)));

    // drop counter saturation
    for (int i = 0; i < 260; i++) begin fd = 1; cyc(); end
    check_eq("drop_sat", 32'(drop3), 32'd255);
    vlp = 1; cyc();

    // randomized traffic with occasional mid-frame resets
    for (int n = 0; n < 3000; n++) begin
      int x, y, a, r;
      rst_n = ($urandom_range(0, 199) != 0);
      wr_valid = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 19);
      if (r < 17) wr_addr = 16'(($urandom_range(0, 3)) * 320 + $urandom_range(0, 7));
      else if (r == 17) wr_addr = 16'($urandom_range(57599, 57600));
      else wr_addr = 16'($urandom_range(0, 65535));
      wr_pixel = 9'($urandom_range(0, 511));
      fd  = ($urandom_range(0, 29) == 0);
      vlp = ($urandom_range(0, 24) == 0);
      x = $urandom_range(0, 7); y = $urandom_range(0, 3); a = y * 320 + x;
      if ($urandom_range(0, 4) != 0 && mem_m.exists(key(0, m_disp[0], a))
          && mem_m.exists(key(1, m_disp[1], a))) begin
        hcount = 11'(x * 4 + $urandom_range(0, 3));
        vcount = 10'(y * 4 + $urandom_range(0, 3));
      end else if ($urandom_range(0, 1) == 1) begin
        hcount = 11'($urandom_range(1280, 2047)); vcount = 10'($urandom_range(0, 1023));
      end else begin
        hcount = 11'($urandom_range(0, 1279)); vcount = 10'($urandom_range(720, 1023));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
